// File: rtl/fetch_unit.sv
// ---------------------------------------------------------------------------
// fetch_unit
//
// Fetch stage of the 3-stage pipelined core. Generates the program counter,
// runs a request/acknowledge handshake with instruction memory and presents
// each fetched instruction with its PC and PC+4 to the fetch/decode register.
// A one-entry skid buffer absorbs decode stalls. Redirects from execute
// discard wrong-path fetches, including a response that is still in flight.
//
// Ports:
//   clk_i, rst_i          clock (rising edge), async active-high reset
//   stall_i               decode cannot accept; output register holds
//   br_taken_i            redirect request from execute
//   br_target_i           redirect target PC
//   imem_req_o            instruction memory request
//   imem_addr_o           request address (stable until acknowledged)
//   imem_ack_i            memory response; imem_rdata_i valid this cycle
//   imem_rdata_i          fetched instruction word
//   instr_f_o             instruction to the pipeline register
//   pc_f_o                PC of instr_f_o
//   pc_plus_4_f_o         pc_f_o + 4
//   valid_f_o             outputs hold a real instruction (0 = bubble)
//   misalign_o            misaligned redirect target flag
//
// Build option:
//   FETCH_MISALIGN_CHECK_EN  when defined, a redirect target with nonzero
//                            low bits is forced to word alignment and
//                            misalign_o pulses for one cycle. When undefined
//                            the target is used as-is and misalign_o is 0.
// ---------------------------------------------------------------------------
module fetch_unit #(
  parameter int            DW       = 32,
  parameter logic [DW-1:0] RESET_PC = '0
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          stall_i,
  input  logic          br_taken_i,
  input  logic [DW-1:0] br_target_i,
  output logic          imem_req_o,
  output logic [DW-1:0] imem_addr_o,
  input  logic          imem_ack_i,
  input  logic [DW-1:0] imem_rdata_i,
  output logic [DW-1:0] instr_f_o,
  output logic [DW-1:0] pc_f_o,
  output logic [DW-1:0] pc_plus_4_f_o,
  output logic          valid_f_o,
  output logic          misalign_o
);

  localparam logic [0:0]    ST_IDLE = 1'b0;
  localparam logic [0:0]    ST_REQ  = 1'b1;
  localparam logic [DW-1:0] PC_INC  = DW'(4);

  logic [0:0]    state_q, state_d;
  logic [DW-1:0] pc_q, pc_d;
  logic [DW-1:0] addr_q, addr_d;
  logic          kill_q, kill_d;

  // Output register O
  logic          o_valid_q, o_valid_d;
  logic [DW-1:0] o_instr_q, o_instr_d;
  logic [DW-1:0] o_pc_q, o_pc_d;
  logic [DW-1:0] o_pc4_q, o_pc4_d;

  // Skid register S
  logic          s_valid_q, s_valid_d;
  logic [DW-1:0] s_instr_q, s_instr_d;
  logic [DW-1:0] s_pc_q, s_pc_d;

  logic [DW-1:0] br_target_eff;
  logic [DW-1:0] addr_plus4;
  logic          to_skid;

  assign addr_plus4 = addr_q + PC_INC;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic misalign_q;

  assign br_target_eff = {br_target_i[DW-1:2], 2'b00};
  assign misalign_o    = misalign_q;

  // One-cycle flag in the cycle after a redirect to a misaligned target.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      misalign_q <= 1'b0;
    end else begin
      misalign_q <= br_taken_i && (br_target_i[1:0] != 2'b00);
    end
  end
`else
  assign br_target_eff = br_target_i;
  assign misalign_o    = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    addr_d    = addr_q;
    kill_d    = kill_q;
    o_valid_d = o_valid_q;
    o_instr_d = o_instr_q;
    o_pc_d    = o_pc_q;
    o_pc4_d   = o_pc4_q;
    s_valid_d = s_valid_q;
    s_instr_d = s_instr_q;
    s_pc_d    = s_pc_q;
    to_skid   = 1'b0;

    if (br_taken_i) begin
      // Redirect wins over stall and ack: flush everything younger.
      o_valid_d = 1'b0;
      s_valid_d = 1'b0;
      pc_d      = br_target_eff;
      if (state_q == ST_IDLE) begin
        state_d = ST_REQ;
        addr_d  = br_target_eff;
      end else if (imem_ack_i) begin
        // Wrong-path data arrives now and is dropped; retarget directly.
        addr_d = br_target_eff;
        kill_d = 1'b0;
      end else begin
        // The outstanding request must complete with its address held;
        // its response is discarded when it arrives.
        kill_d = 1'b1;
      end
    end else begin
      if (!stall_i) begin
        if (s_valid_q) begin
          o_valid_d = 1'b1;
          o_instr_d = s_instr_q;
          o_pc_d    = s_pc_q;
          o_pc4_d   = s_pc_q + PC_INC;
          s_valid_d = 1'b0;
        end else begin
          o_valid_d = 1'b0;
        end
      end

      if (state_q == ST_IDLE) begin
        if (!s_valid_q) begin
          state_d = ST_REQ;
          addr_d  = pc_q;
        end
      end else if (imem_ack_i) begin
        if (kill_q) begin
          // pc_q already holds the redirect target.
          kill_d = 1'b0;
          addr_d = pc_q;
        end else begin
          pc_d = addr_plus4;
          if ((!o_valid_q || !stall_i) && !s_valid_q) begin
            o_valid_d = 1'b1;
            o_instr_d = imem_rdata_i;
            o_pc_d    = addr_q;
            o_pc4_d   = addr_plus4;
          end else begin
            to_skid   = 1'b1;
            s_valid_d = 1'b1;
            s_instr_d = imem_rdata_i;
            s_pc_d    = addr_q;
          end
          // A full skid buffer stops fetching so at most one response
          // lands there while decode is stalled.
          if (to_skid) begin
            state_d = ST_IDLE;
          end else begin
            addr_d = addr_plus4;
          end
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      pc_q      <= RESET_PC;
      addr_q    <= RESET_PC;
      kill_q    <= 1'b0;
      o_valid_q <= 1'b0;
      o_instr_q <= '0;
      o_pc_q    <= '0;
      o_pc4_q   <= '0;
      s_valid_q <= 1'b0;
      s_instr_q <= '0;
      s_pc_q    <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      kill_q    <= kill_d;
      o_valid_q <= o_valid_d;
      o_instr_q <= o_instr_d;
      o_pc_q    <= o_pc_d;
      o_pc4_q   <= o_pc4_d;
      s_valid_q <= s_valid_d;
      s_instr_q <= s_instr_d;
      s_pc_q    <= s_pc_d;
    end
  end

  assign imem_req_o    = (state_q == ST_REQ);
  assign imem_addr_o   = addr_q;
  assign instr_f_o     = o_instr_q;
  assign pc_f_o        = o_pc_q;
  assign pc_plus_4_f_o = o_pc4_q;
  assign valid_f_o     = o_valid_q;

endmodule

// File: tb/tb_fetch_unit.sv
// ---------------------------------------------------------------------------
// tb_fetch_unit
//
// Directed bench for fetch_unit. A behavioural instruction memory returns
// addr ^ 32'hA5A5A5A5 after a selectable number of wait cycles. Expected
// instructions are queued as the stimulus is issued; a monitor pops one
// entry each time decode consumes a valid instruction. Cycle-specific
// behaviour (addresses, bubbles, stall holding, misalign flag) is checked
// inline by the stimulus process.
// ---------------------------------------------------------------------------
module tb_fetch_unit;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } expT;

  logic        clock;
  logic        reset;
  logic        stall;
  logic        brTaken;
  logic [31:0] brTarget;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic [31:0] instrF;
  logic [31:0] pcF;
  logic [31:0] pcPlus4F;
  logic        validF;
  logic        misalign;

  int          memLatency;
  int          waitCnt;
  int          checks;
  int          errors;
  expT         expQ[$];
  expT         monExp;

  fetch_unit dut (
    .clk_i         (clock),
    .rst_i         (reset),
    .stall_i       (stall),
    .br_taken_i    (brTaken),
    .br_target_i   (brTarget),
    .imem_req_o    (imemReq),
    .imem_addr_o   (imemAddr),
    .imem_ack_i    (imemAck),
    .imem_rdata_i  (imemRdata),
    .instr_f_o     (instrF),
    .pc_f_o        (pcF),
    .pc_plus_4_f_o (pcPlus4F),
    .valid_f_o     (validF),
    .misalign_o    (misalign)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Memory model: ack after memLatency wait cycles of a held request.
  assign imemAck   = imemReq && (waitCnt == memLatency);
  assign imemRdata = imemAddr ^ 32'hA5A5_A5A5;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      waitCnt <= 0;
    end else if (imemReq && !imemAck) begin
      waitCnt <= waitCnt + 1;
    end else begin
      waitCnt <= 0;
    end
  end

  // Scoreboard monitor: decode consumes O whenever valid and not stalled.
  always @(negedge clock) begin
    if (!reset && validF && !stall) begin
      checks++;
      if (expQ.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_instr: got instr=%h pc=%h pc4=%h, expected none",
                 instrF, pcF, pcPlus4F);
      end else begin
        monExp = expQ.pop_front();
        if (instrF !== monExp.instr || pcF !== monExp.pc || pcPlus4F !== monExp.pc4) begin
          errors++;
          $display("[TB] FAIL stream_instr: got instr=%h pc=%h pc4=%h, expected instr=%h pc=%h pc4=%h",
                   instrF, pcF, pcPlus4F, monExp.instr, monExp.pc, monExp.pc4);
        end
      end
    end
  end

  task automatic nextCycle();
    @(posedge clock);
    #1;
  endtask

  task automatic applyStimulus(input logic st, input logic br, input logic [31:0] tgt);
    stall    = st;
    brTaken  = br;
    brTarget = tgt;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic pushExp(input logic [31:0] instr, input logic [31:0] pc,
                         input logic [31:0] pc4);
    expT e;
    e.instr = instr;
    e.pc    = pc;
    e.pc4   = pc4;
    expQ.push_back(e);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    memLatency = 0;
    reset      = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0);
    nextCycle();
    nextCycle();

    // Reset state
    checkOutput("reset_req",      {31'b0, imemReq},  32'h0);
    checkOutput("reset_addr",     imemAddr,          32'h0);
    checkOutput("reset_valid",    {31'b0, validF},   32'h0);
    checkOutput("reset_instr",    instrF,            32'h0);
    checkOutput("reset_pc",       pcF,               32'h0);
    checkOutput("reset_pc4",      pcPlus4F,          32'h0);
    checkOutput("reset_misalign", {31'b0, misalign}, 32'h0);
    reset = 1'b0;

    pushExp(32'hA5A5_A5A5, 32'h0000_0000, 32'h0000_0004);
    pushExp(32'hA5A5_A5A1, 32'h0000_0004, 32'h0000_0008);
    pushExp(32'hA5A5_A5AD, 32'h0000_0008, 32'h0000_000C);
    pushExp(32'hA5A5_A5A9, 32'h0000_000C, 32'h0000_0010);
    pushExp(32'hA5A5_A5B5, 32'h0000_0010, 32'h0000_0014);

    // Zero-wait streaming: 0,4,8 on consecutive cycles
    nextCycle();
    checkOutput("first_req",   {31'b0, imemReq}, 32'h1);
    checkOutput("first_addr",  imemAddr,         32'h0);
    nextCycle();
    checkOutput("addr_4",      imemAddr,         32'h4);
    checkOutput("first_valid", {31'b0, validF},  32'h1);
    checkOutput("first_pc",    pcF,              32'h0);
    nextCycle();
    checkOutput("addr_8",      imemAddr,         32'h8);
    nextCycle();
    checkOutput("o_pc8",       pcF,              32'h8);

    // Stall three cycles with PC 8 in O; PC 12 lands in the skid buffer
    applyStimulus(1'b1, 1'b0, 32'h0);
    nextCycle();
    checkOutput("stall_req_off", {31'b0, imemReq}, 32'h0);
    checkOutput("stall_hold1",   pcF,              32'h8);
    nextCycle();
    checkOutput("stall_req_off2", {31'b0, imemReq}, 32'h0);
    nextCycle();
    checkOutput("stall_hold3",   pcF,              32'h8);
    checkOutput("stall_valid3",  {31'b0, validF},  32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    nextCycle();
    checkOutput("skid_pc12",     pcF,              32'hC);
    checkOutput("skid_valid",    {31'b0, validF},  32'h1);
    nextCycle();
    checkOutput("refill_bubble", {31'b0, validF},  32'h0);
    checkOutput("refill_addr",   imemAddr,         32'h10);
    nextCycle();
    checkOutput("refill_pc16",   pcF,              32'h10);

    // Two-wait memory; redirect to 0x20 kills the in-flight fetch of 0x14
    memLatency = 2;
    applyStimulus(1'b0, 1'b1, 32'h20);
    nextCycle();
    checkOutput("kill_valid",    {31'b0, validF},  32'h0);
    checkOutput("kill_addr_hold", imemAddr,        32'h14);
    applyStimulus(1'b0, 1'b0, 32'h0);
    nextCycle();
    checkOutput("kill_addr_hold2", imemAddr,       32'h14);
    nextCycle();
    checkOutput("retarget_20",   imemAddr,         32'h20);

    // Redirect to 0x100 while 0x20 is outstanding
    pushExp(32'hA5A5_A4A5, 32'h0000_0100, 32'h0000_0104);
    applyStimulus(1'b0, 1'b1, 32'h100);
    nextCycle();
    checkOutput("redir_bubble",  {31'b0, validF},  32'h0);
    checkOutput("redir_hold20",  imemAddr,         32'h20);
    applyStimulus(1'b0, 1'b0, 32'h0);
    nextCycle();
    checkOutput("redir_hold20b", imemAddr,         32'h20);
    nextCycle();
    checkOutput("redir_addr100", imemAddr,         32'h100);
    checkOutput("drop_valid",    {31'b0, validF},  32'h0);
    nextCycle();
    nextCycle();
    checkOutput("wait_valid",    {31'b0, validF},  32'h0);
    nextCycle();
    checkOutput("arrive_pc100",  pcF,              32'h100);
    checkOutput("arrive_valid",  {31'b0, validF},  32'h1);

    // Redirect to 0x40 coincident with ack while stalled
    memLatency = 0;
    nextCycle();
    pushExp(32'hA5A5_A5E5, 32'h0000_0040, 32'h0000_0044);
    pushExp(32'hA5A5_A5E1, 32'h0000_0044, 32'h0000_0048);
    applyStimulus(1'b1, 1'b1, 32'h40);
    nextCycle();
    checkOutput("flush_valid",   {31'b0, validF},  32'h0);
    checkOutput("flush_addr40",  imemAddr,         32'h40);
    checkOutput("flush_req",     {31'b0, imemReq}, 32'h1);
    applyStimulus(1'b0, 1'b0, 32'h0);
    nextCycle();
    nextCycle();

    // Wrap-around at the top of the address space
    pushExp(32'h5A5A_5A59, 32'hFFFF_FFFC, 32'h0000_0000);
    pushExp(32'hA5A5_A5A5, 32'h0000_0000, 32'h0000_0004);
    applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
    nextCycle();
    checkOutput("wrap_addr",     imemAddr,         32'hFFFF_FFFC);
    applyStimulus(1'b0, 1'b0, 32'h0);
    nextCycle();
    checkOutput("wrap_pc4",      pcPlus4F,         32'h0);
    checkOutput("wrap_next",     imemAddr,         32'h0);
    nextCycle();

    // Misaligned redirect
`ifdef FETCH_MISALIGN_CHECK_EN
    pushExp(32'hA5A5_A4A5, 32'h0000_0100, 32'h0000_0104);
`else
    pushExp(32'hA5A5_A4A7, 32'h0000_0102, 32'h0000_0106);
`endif
    applyStimulus(1'b0, 1'b1, 32'h102);
    nextCycle();
`ifdef FETCH_MISALIGN_CHECK_EN
    checkOutput("misalign_pulse", {31'b0, misalign}, 32'h1);
    checkOutput("misalign_addr",  imemAddr,          32'h100);
`else
    checkOutput("misalign_pulse", {31'b0, misalign}, 32'h0);
    checkOutput("misalign_addr",  imemAddr,          32'h102);
`endif
    applyStimulus(1'b0, 1'b0, 32'h0);
    nextCycle();
    checkOutput("misalign_clear", {31'b0, misalign}, 32'h0);
    nextCycle();

    // Long stall, then asynchronous reset mid-run
    applyStimulus(1'b1, 1'b0, 32'h0);
    nextCycle();
    checkOutput("final_req_off", {31'b0, imemReq}, 32'h0);
    nextCycle();
`ifdef FETCH_MISALIGN_CHECK_EN
    checkOutput("final_hold_pc", pcF, 32'h104);
`else
    checkOutput("final_hold_pc", pcF, 32'h106);
`endif
    reset = 1'b1;
    #1;
    checkOutput("async_req",   {31'b0, imemReq}, 32'h0);
    checkOutput("async_valid", {31'b0, validF},  32'h0);
    checkOutput("async_addr",  imemAddr,         32'h0);
    checkOutput("scoreboard_drained", expQ.size(), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Fetch stage of the 3-stage pipelined core. Generates the program counter and runs a request/acknowledge handshake with instruction memory. Presents each fetched instruction, its PC and PC+4 to the fetch/decode pipeline register. Absorbs decode stalls with a one-entry skid buffer and discards wrong-path fetches on branch/jump redirects from execute.

## Interface
- `DW`, 32: data/address width
- `RESET_PC`, 32'h0000_0000: first fetch address after reset
- `clk_i` in 1: clock, all state updates on rising edge
- `rst_i` in 1: reset, asynchronous, active-high
- `stall_i` in 1: decode cannot accept; output register must hold
- `br_taken_i` in 1: redirect request from execute
- `br_target_i` in DW: redirect target PC
- `imem_req_o` out 1: instruction memory request
- `imem_addr_o` out DW: request address, stable while `imem_req_o`=1 and no ack
- `imem_ack_i` in 1: memory response; `imem_rdata_i` valid this cycle
- `imem_rdata_i` in DW: fetched instruction
- `instr_f_o` out DW: instruction to pipeline register
- `pc_f_o` out DW: PC of `instr_f_o`
- `pc_plus_4_f_o` out DW: `pc_f_o`+4
- `valid_f_o` out 1: outputs hold a real instruction (0 = bubble)
- `misalign_o` out 1: misaligned redirect target flag (see Configuration)

## Operation
- State: next-fetch PC `pc_q`, request address `addr_q`, output register O, skid register S, kill flag, FSM {IDLE, REQ}.
- Reset values: FSM=IDLE, `pc_q`=`addr_q`=RESET_PC, O and S invalid with zero data, kill=0. All outputs are 0, except `imem_addr_o`=RESET_PC.
- `imem_req_o` = (FSM==REQ). `imem_addr_o` = `addr_q`.
- IDLE→REQ when S is invalid; `addr_q`<=`pc_q`.
- In REQ the request holds until `imem_ack_i`. Ack in the same cycle as request is legal.
- On ack without kill and without redirect:
  - If O is empty or being consumed (`stall_i`=0) and S is empty: data goes to O.
  - Otherwise: data goes to S.
  - `pc_q`<=`addr_q`+4.
  - If S is valid next cycle: go to IDLE. Else stay in REQ with `addr_q`<=`addr_q`+4.
- When `stall_i`=0 and S is valid: O<=S and S is cleared.
- `stall_i`=0 with O invalid and S empty: `valid_f_o` goes to 0 (bubble).
- Redirect (`br_taken_i`=1) has priority over stall and ack:
  - O and S are invalidated.
  - `pc_q`<=target.
  - If in REQ without ack this cycle: kill<=1 and `addr_q` is unchanged.
  - If in REQ with ack this cycle: data is dropped, `addr_q`<=target, stay in REQ.
  - If IDLE: go to REQ with `addr_q`<=target.
- Ack with kill=1: data is dropped, kill<=0, `addr_q`<=`pc_q`, stay in REQ.
- Arithmetic is modulo 2^DW. `pc_plus_4` of 32'hFFFF_FFFC is 0.
- Reset asserted mid-transaction: all state returns to reset values immediately. Any outstanding memory response is the memory's responsibility to abandon.

## Timing
- Zero-wait memory (ack in the request cycle): first `valid_f_o` 1 cycle after leaving IDLE, then 1 instruction/cycle.
- Fetch latency = memory latency + 1 cycle (registered O).
- Redirect in cycle t: `valid_f_o`=0 at t+1; target is requested at t+1 (or after the killed ack).
- A stall lasting any number of cycles loses no instruction. At most 1 memory response lands in S.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - A redirect target with `[1:0]`≠0 loads `pc_q`=target & ~3.
  - `misalign_o` pulses high for exactly 1 cycle, the cycle after the redirect.
- Undefined:
  - Target is used unmodified.
  - `misalign_o` is tied 0.

## Test plan
- Reset release, zero-wait memory returning `addr`^32'hA5A5_A5A5 → `imem_addr_o` 0,4,8,… each cycle; `instr_f_o`/`pc_f_o`/`pc_plus_4_f_o` = 0xA5A5A5A5/0/4, then 0xA5A5A5A1/4/8.
- `stall_i` high 3 cycles while O=PC 8 → O holds PC 8. Request for PC 12 completes into S, then `imem_req_o`=0. After release: PC 12, then PC 16, no gap beyond refill.
- Memory with 2-cycle ack latency, redirect to 0x100 while 0x20 is outstanding → `imem_addr_o` stays 0x20 until ack, data dropped. Next request is 0x100, `valid_f_o`=0 until 0x100 arrives.
- Redirect to 0x40 coincident with ack and `stall_i`=1 → O and S are flushed, next `imem_addr_o`=0x40.
- PC 0xFFFF_FFFC fetch → `pc_plus_4_f_o`=0, next address 0.
- With macro defined, redirect to 0x102 → `misalign_o`=1 for 1 cycle, next address 0x100. Without the macro → address 0x102, `misalign_o`=0.
